reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
//
// PURPOSE
//   Parametrised multi-port register file; successor to the fixed 32x32 2R1W file.
//   Configurable width, depth and read/write port counts, plus:
//   - hardware clear sequencer (on reset or on request);
//   - same-cycle write-to-read bypass;
//   - optional hardwired zero register.
//   Sits in the decode/writeback path of the core pipeline.
//
// PARAMETERS
//   DATA_W    32               data width per entry
//   DEPTH     32               number of entries (need not be a power of 2)
//   ADDR_W    $clog2(DEPTH)    address width (derived; do not override)
//   NUM_RD    2                read ports
//   NUM_WR    1                write ports (1..4)
//   ZERO_REG  1                1: entry 0 always reads 0 and ignores writes
//   BYPASS    1                1: same-cycle write data is forwarded to matching reads
//
// PORTS
//   clk        in   1              clock, rising edge
//   rst_n      in   1              asynchronous, active-low reset
//   clr_req    in   1              pulse: start clearing all entries (ignored while init_busy)
//   init_busy  out  1              high while the clear sequence runs
//   wr_en      in   NUM_WR         per-port write enable
//   wr_addr    in   NUM_WR*ADDR_W  packed write addresses, port 0 in the LSBs
//   wr_data    in   NUM_WR*DATA_W  packed write data
//   rd_addr    in   NUM_RD*ADDR_W  packed read addresses
//   rd_data    out  NUM_RD*DATA_W  packed read data (combinational)
//   parity_err out  NUM_RD         per-read-port parity fault (only with REG_FILE_PARITY_EN)
//
// BEHAVIOUR
//   FSM states: INIT, RUN.
//   - rst_n low: go to INIT asynchronously; clr_cnt=0, init_busy=1.
//   - INIT: write 0 to entry clr_cnt each cycle and increment; exit to RUN after the
//     DEPTH-1 write. Takes DEPTH cycles after rst_n deasserts.
//   - RUN: clr_req=1 -> INIT with clr_cnt=0.
//   - rst_n low mid-clear restarts the sequence from 0.
//   During INIT:
//   - all wr_en are ignored; rd_data = 0; parity_err = 0.
//   Writes (RUN only):
//   - committed at the rising edge.
//   - Two ports hitting the same address in one cycle: highest port index wins.
//   - Dropped: address >= DEPTH, or address 0 when ZERO_REG=1.
//   Reads (zero latency, combinational):
//   - Return 0 when address >= DEPTH, or address 0 when ZERO_REG=1.
//   - BYPASS=1: if any enabled, non-dropped write targets the same address this cycle,
//     return that write's data (highest index wins); otherwise return array contents.
//   - BYPASS=0: return the pre-edge array contents.
//   init_busy is registered and asserts in the cycle after clr_req.
//
// CONFIGURATION
//   Macro REG_FILE_PARITY_EN.
//   Defined:
//   - each entry stores an extra even-parity bit, written alongside the data
//     (clear writes 0 with parity 0);
//   - parity_err[i] = recomputed ^ stored parity for array reads;
//   - parity_err[i] is 0 for bypassed, zero-register, out-of-range and INIT reads.
//   Undefined:
//   - no parity storage; the parity_err port does not exist.
//
// STRUCTURE
//   Package reg_file_pkg:
//   - typedef enum logic {INIT, RUN} rf_state_e;
//   - function even_parity(logic [] d);
//   - localparam MAX_WR = 4.
//   Sub-module reg_file_clr_seq:
//   - owns the FSM, clr_cnt and init_busy;
//   - drives clr_we / clr_addr into the write mux of reg_file_mp.
//
// TESTING
//   1. Release rst_n; hold wr_en=1 to addr 5
//      -> init_busy high for exactly DEPTH cycles; after it drops, read addr 5 = 0.
//   2. RUN: write 0xDEADBEEF to addr 7; same cycle read addr 7 on rd port 1
//      -> BYPASS=1: 0xDEADBEEF that cycle; BYPASS=0: old value, then 0xDEADBEEF next cycle.
//   3. NUM_WR=2: port0 writes 0x1, port1 writes 0x2, both to addr 3
//      -> addr 3 reads 0x2.
//   4. ZERO_REG=1: write 0xFFFFFFFF to addr 0
//      -> addr 0 reads 0 on all ports; no other entry changes.
//   5. Fill entries with 0xA5A5A5A5; pulse clr_req; pull rst_n low at clear count 10
//      -> clear restarts from 0; after DEPTH cycles all entries read 0.
//   6. REG_FILE_PARITY_EN: force-flip bit 0 of a stored entry via hierarchical force
//      -> parity_err=1 on the reading port; unaffected ports stay 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and helpers for the multi-port register file.
package reg_file_pkg;
   typedef enum logic {INIT, RUN} rf_state_e;
   localparam int MAX_WR = 4;
   localparam int MAX_DATA_W = 1024;
   function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq: clear sequencer; walks every entry writing zero after reset or clr_req.
module reg_file_clr_seq
   import reg_file_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              init_busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);
   rf_state_e state, state_nx;
   logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
   logic last;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         clr_cnt <= '0;
      end else begin
         state <= state_nx;
         clr_cnt <= clr_cnt_nx;
      end
   end
   assign last = clr_cnt == ADDR_W'(DEPTH - 1);
   always_comb begin
      state_nx = state;
      clr_cnt_nx = clr_cnt;
      if (state == INIT) begin
         state_nx = last ? RUN : INIT;
         clr_cnt_nx = last ? '0 : clr_cnt + ADDR_W'(1);
      end else if (clr_req) begin
         state_nx = INIT;
         clr_cnt_nx = '0;
      end
   end
   assign init_busy = state == INIT;
   assign clr_we = init_busy;
   assign clr_addr = clr_cnt;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with clear sequencer and write bypass.
// Define REG_FILE_PARITY_EN to add per-entry even parity and the parity_err output.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH = 32,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr_req,
   output logic                     init_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data
`ifdef REG_FILE_PARITY_EN
   ,
   output logic [NUM_RD-1:0]        parity_err
`endif
);
   localparam int NW = NUM_WR < MAX_WR ? NUM_WR : MAX_WR;
   logic clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic [NUM_WR-1:0] wv;
   logic [DATA_W-1:0] mem [DEPTH];
`ifdef REG_FILE_PARITY_EN
   logic par_mem [DEPTH];
`endif
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return 32'(a) < DEPTH && !(ZERO_REG != 0 && a == '0);
   endfunction
   reg_file_clr_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
      .init_busy(init_busy), .clr_we(clr_we), .clr_addr(clr_addr)
   );
   always_comb begin
      wv = '0;
      for (int p = 0; p < NW; p++)
         wv[p] = !init_busy && wr_en[p] && addr_ok(wr_addr[p*ADDR_W +: ADDR_W]);
   end
   // Ascending port order makes the highest-index writer win on collisions.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
`ifdef REG_FILE_PARITY_EN
         par_mem[clr_addr] <= 1'b0;
`endif
      end else begin
         for (int p = 0; p < NW; p++)
            if (wv[p]) begin
               mem[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
`ifdef REG_FILE_PARITY_EN
               par_mem[wr_addr[p*ADDR_W +: ADDR_W]] <= even_parity(MAX_DATA_W'(wr_data[p*DATA_W +: DATA_W]));
`endif
            end
      end
   end
   always_comb begin
      rd_data = '0;
`ifdef REG_FILE_PARITY_EN
      parity_err = '0;
`endif
      for (int r = 0; r < NUM_RD; r++)
         if (!init_busy && addr_ok(rd_addr[r*ADDR_W +: ADDR_W])) begin
            rd_data[r*DATA_W +: DATA_W] = mem[rd_addr[r*ADDR_W +: ADDR_W]];
`ifdef REG_FILE_PARITY_EN
            parity_err[r] = even_parity(MAX_DATA_W'(mem[rd_addr[r*ADDR_W +: ADDR_W]]))
                            ^ par_mem[rd_addr[r*ADDR_W +: ADDR_W]];
`endif
            for (int p = 0; p < NW; p++)
               if (BYPASS != 0 && wv[p] && wr_addr[p*ADDR_W +: ADDR_W] == rd_addr[r*ADDR_W +: ADDR_W]) begin
                  rd_data[r*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
`ifdef REG_FILE_PARITY_EN
                  parity_err[r] = 1'b0;
`endif
               end
         end
   end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp (DEPTH=24, 2 write ports).
module tb_reg_file_mp;
   localparam int DW = 32, DEPTH = 24, AW = 5, NR = 2, NWR = 2;
   logic clk = 1'b0, rst_n = 1'b0, clr_req = 1'b0, init_busy;
   logic [NWR-1:0] wr_en = '0;
   logic [NWR*AW-1:0] wr_addr = '0;
   logic [NWR*DW-1:0] wr_data = '0;
   logic [NR*AW-1:0] rd_addr = '0;
   logic [NR*DW-1:0] rd_data;
`ifdef REG_FILE_PARITY_EN
   logic [NR-1:0] parity_err;
`endif
   int checks = 0, passed = 0;
   reg_file_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NR), .NUM_WR(NWR), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(init_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef REG_FILE_PARITY_EN
      , .parity_err(parity_err)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en[p] = 1'b1;
      wr_addr[p*AW +: AW] = a;
      wr_data[p*DW +: DW] = d;
   endtask
   task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
      #1;
   endtask
   task automatic wait_clear(input string tag);
      int n = 0;
      while (init_busy && n < 200) begin
         tick();
         n++;
      end
      chk(tag, 32'(n), 32'(DEPTH));
   endtask
   initial begin
      wr(0, 5'd5, 32'h5555_5555);
      rd(5'd5, 5'd5);
      #12;
      chk("reset_busy", 32'(init_busy), 32'd1);
      chk("reset_rd", rd_data[31:0], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("init_rd_zero", rd_data[DW +: DW], 32'h0);
      wait_clear("init_cycles");
      wr_en = '0;
      rd(5'd5, 5'd6);
      chk("init_wr_ignored", rd_data[31:0], 32'h0);
      wr(0, 5'd7, 32'hDEADBEEF);
      rd(5'd6, 5'd7);
      chk("bypass_rd1", rd_data[DW +: DW], 32'hDEADBEEF);
      chk("bypass_other", rd_data[31:0], 32'h0);
      tick();
      wr_en = '0;
      rd(5'd6, 5'd7);
      chk("stored_rd1", rd_data[DW +: DW], 32'hDEADBEEF);
      wr(0, 5'd3, 32'h1);
      wr(1, 5'd3, 32'h2);
      rd(5'd3, 5'd7);
      chk("collide_bypass", rd_data[31:0], 32'h2);
      tick();
      wr_en = '0;
      rd(5'd3, 5'd3);
      chk("collide_stored", rd_data[31:0], 32'h2);
      wr(0, 5'd0, 32'hFFFF_FFFF);
      rd(5'd0, 5'd0);
      chk("zero_bypass0", rd_data[31:0], 32'h0);
      chk("zero_bypass1", rd_data[DW +: DW], 32'h0);
      tick();
      wr_en = '0;
      rd(5'd0, 5'd0);
      chk("zero_rd0", rd_data[31:0], 32'h0);
      chk("zero_rd1", rd_data[DW +: DW], 32'h0);
      rd(5'd3, 5'd7);
      chk("zero_keep3", rd_data[31:0], 32'h2);
      chk("zero_keep7", rd_data[DW +: DW], 32'hDEADBEEF);
      wr(1, 5'd30, 32'h1234_5678);
      wr(0, 5'd23, 32'hCAFE_0023);
      rd(5'd30, 5'd23);
      chk("oor_bypass", rd_data[31:0], 32'h0);
      chk("last_bypass", rd_data[DW +: DW], 32'hCAFE_0023);
      tick();
      wr_en = '0;
      rd(5'd30, 5'd23);
      chk("oor_rd", rd_data[31:0], 32'h0);
      chk("last_rd", rd_data[DW +: DW], 32'hCAFE_0023);
      for (int a = 1; a < DEPTH; a++) begin
         wr(0, 5'(a), 32'hA5A5_A5A5);
         tick();
      end
      wr_en = '0;
      rd(5'd1, 5'd23);
      chk("fill_first", rd_data[31:0], 32'hA5A5_A5A5);
      chk("fill_last", rd_data[DW +: DW], 32'hA5A5_A5A5);
      clr_req = 1'b1;
      #1;
      chk("busy_not_yet", 32'(init_busy), 32'd0);
      tick();
      clr_req = 1'b0;
      #1;
      chk("clr_busy", 32'(init_busy), 32'd1);
      chk("clr_rd_zero", rd_data[31:0], 32'h0);
      for (int i = 0; i < 10; i++) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(init_busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      wait_clear("restart_cycles");
      for (int a = 0; a < DEPTH; a += 2) begin
         rd(5'(a), 5'(a + 1));
         chk($sformatf("clr_rd_%0d", a), rd_data[31:0], 32'h0);
         chk($sformatf("clr_rd_%0d", a + 1), rd_data[DW +: DW], 32'h0);
      end
`ifdef REG_FILE_PARITY_EN
      wr(0, 5'd9, 32'h0000_00F0);
      tick();
      wr_en = '0;
      rd(5'd9, 5'd8);
      chk("par_clean", 32'(parity_err), 32'd0);
      force dut.mem[9] = 32'h0000_00F1;
      rd(5'd9, 5'd8);
      chk("par_err0", 32'(parity_err[0]), 32'd1);
      chk("par_ok1", 32'(parity_err[1]), 32'd0);
      release dut.mem[9];
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
